vec_add_arbiter: RTL and testbench
==================================

VEC_ADD_ARBITER -- requirements
Module: vec_add_arbiter

Interface
REQ-001 Parameter VEC_LEN, default `MAX_EMBEDDING_DIM, elements per vector.
REQ-002 Parameter DATA_WIDTH, default `INTEGER_WIDTH, bits per element.
REQ-003 Parameter TAG_DEPTH, default 4, maximum in-flight adds; power of two, >=2.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-low (asserted at 0).
REQ-006 r0_vld/r1_vld  input  1 each  requester k operand valid.
REQ-007 r0_rdy/r1_rdy  output  1 each  requester k operand accepted this cycle.
REQ-008 r0_a, r0_b, r1_a, r1_b  input  [DATA_WIDTH-1:0] x VEC_LEN  operand vectors.
REQ-009 add_vld  output  1  operands valid toward the shared adder.
REQ-010 add_rdy  input  1  shared adder accepts operands.
REQ-011 add_a, add_b  output  [DATA_WIDTH-1:0] x VEC_LEN  muxed operands.
REQ-012 sum_vld  input  1, sum_rdy  output  1, sum_in  input  [DATA_WIDTH-1:0] x VEC_LEN  adder result port.
REQ-013 o0_vld/o1_vld  output  1, o0_rdy/o1_rdy  input  1, o0_sum/o1_sum  output  vector  routed results.
REQ-014 inflight  output  [$clog2(TAG_DEPTH):0]  current in-flight count.
REQ-015 err  output  1  sticky protocol-error flag.

Function
REQ-016 Grant SHALL be round-robin: pointer rr (reset 0) names the preferred requester; if only one valid, it wins.
REQ-017 After an add handshake (add_vld & add_rdy) granted to k, rr SHALL become 1-k next cycle; otherwise rr holds.
REQ-018 FSM states IDLE and LOCKED; reset to IDLE.
REQ-019 IDLE: grant computed combinationally per REQ-016; if add_vld=1 and add_rdy=0, go LOCKED, registering the grant in gnt_q.
REQ-020 LOCKED: grant SHALL be gnt_q regardless of other requester; on add handshake return to IDLE.
REQ-021 add_vld = (granted requester's vld) & !full; add_a/add_b = granted requester's operands; zeros when add_vld=0.
REQ-022 rk_rdy = (k granted) & add_rdy & !full; the non-granted requester's rdy SHALL be 0.
REQ-023 Tag FIFO (TAG_DEPTH entries, 1 bit each) SHALL push granted index on every add handshake; full when count==TAG_DEPTH.
REQ-024 When full, add_vld SHALL be 0 even if a pop occurs the same cycle (no bypass).
REQ-025 ok_vld = sum_vld & !empty & (head==k); ok_sum = sum_in; other output vld 0 and sum zeros.
REQ-026 sum_rdy = !empty & o_head_rdy; FIFO pops on sum_vld & sum_rdy.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo TAG_DEPTH.
REQ-028 sum_vld=1 while empty SHALL set err (sticky until reset); sum_rdy stays 0.
REQ-029 Results SHALL be returned in issue order; no reordering; zero added latency on both paths.
REQ-030 inflight SHALL equal FIFO count, registered.

Reset
REQ-031 On rst=0, immediately: state IDLE, rr=0, gnt_q=0, FIFO pointers/count=0, err=0; hence add_vld, sum_rdy, o0_vld, o1_vld, r0_rdy, r1_rdy all 0, inflight=0.
REQ-032 Reset mid-operation SHALL discard all in-flight tags; results arriving after reset are errors per REQ-028.
REQ-033 Deassertion SHALL be synchronised so first active edge sees clean state.

Verification (VEC_LEN=4, DATA_WIDTH=8, TAG_DEPTH=4)
REQ-034 Both vld continuously, add_rdy=1 -> grants alternate r0,r1,r0,r1; inflight 1..4 then add_vld=0 at full.
REQ-035 r0 a={1,2,3,4} b={10,10,10,10}, then r1; adder echoes a+b -> o0_sum={11,12,13,14} first, then o1 result; in-order.
REQ-036 r1 valid alone, add_rdy=0 two cycles, r0 asserts during stall -> add_a stays r1's, LOCKED held, r1 wins on handshake.
REQ-037 FIFO full, same-cycle sum pop and pending request -> add_vld=0 that cycle, inflight 4->3, issue next cycle.
REQ-038 sum_vld=1 with inflight=0 -> err=1 next edge, sum_rdy=0, err remains 1 until rst=0.
REQ-039 rst=0 asserted asynchronously with inflight=3 -> all outputs 0 before next edge, inflight=0.

Source files
------------

// File: rtl/vec_add_arbiter.sv
// Two-requester round-robin front end for a shared vector adder.
// A tag FIFO records issue order so the results go back to the requester that issued them.
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 4
`endif
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif

module vec_add_arbiter #(
  parameter int VEC_LEN    = `MAX_EMBEDDING_DIM,
  parameter int DATA_WIDTH = `INTEGER_WIDTH,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               r0_vld,
  output logic                               r0_rdy,
  input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0] r0_a,
  input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0] r0_b,
  input  logic                               r1_vld,
  output logic                               r1_rdy,
  input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0] r1_a,
  input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0] r1_b,
  output logic                               add_vld,
  input  logic                               add_rdy,
  output logic [VEC_LEN-1:0][DATA_WIDTH-1:0] add_a,
  output logic [VEC_LEN-1:0][DATA_WIDTH-1:0] add_b,
  input  logic                               sum_vld,
  output logic                               sum_rdy,
  input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0] sum_in,
  output logic                               o0_vld,
  input  logic                               o0_rdy,
  output logic [VEC_LEN-1:0][DATA_WIDTH-1:0] o0_sum,
  output logic                               o1_vld,
  input  logic                               o1_rdy,
  output logic [VEC_LEN-1:0][DATA_WIDTH-1:0] o1_sum,
  output logic [$clog2(TAG_DEPTH):0]         inflight,
  output logic                               err
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(TAG_DEPTH);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [1:0]      rst_sync_q;
  logic            rst_n_int;
  logic            rr_q, gnt_q, gnt, gnt_vld;
  logic [TAG_DEPTH-1:0] tags_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     count_q;
  logic            full, empty, head, push, pop;

  // Assertion propagates asynchronously; release reaches the core two edges later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = tags_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    gnt     = 1'b0;
    if (state_q == LOCKED)      gnt = gnt_q;
    else if (r0_vld && r1_vld)  gnt = rr_q;
    else                        gnt = r1_vld;
    gnt_vld = gnt ? r1_vld : r0_vld;
    // No bypass: a same-cycle pop does not free a slot for issue.
    add_vld = rst_n_int & gnt_vld & ~full;
    push    = add_vld & add_rdy;
    r0_rdy  = push & ~gnt;
    r1_rdy  = push & gnt;
    add_a   = '0;
    add_b   = '0;
    if (add_vld) begin
      add_a = gnt ? r1_a : r0_a;
      add_b = gnt ? r1_b : r0_b;
    end
    case (state_q)
      IDLE:    if (add_vld && !add_rdy) state_d = LOCKED;
      LOCKED:  if (push)                state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_comb begin
    sum_rdy = ~empty & (head ? o1_rdy : o0_rdy);
    pop     = sum_vld & sum_rdy;
    o0_vld  = sum_vld & ~empty & ~head;
    o1_vld  = sum_vld & ~empty & head;
    o0_sum  = '0;
    o1_sum  = '0;
    if (o0_vld) o0_sum = sum_in;
    if (o1_vld) o1_sum = sum_in;
  end

  assign inflight = count_q;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      gnt_q    <= 1'b0;
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == LOCKED) gnt_q <= gnt;
      if (push) begin
        rr_q             <= ~gnt;
        tags_q[wr_ptr_q] <= gnt;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (sum_vld && empty) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vec_add_arbiter.sv
// Self-checking bench for vec_add_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based model of arbitration and in-order return.
module tb_vec_add_arbiter;

  typedef logic [3:0][7:0] vec_t;
  typedef struct {int tag; vec_t sum;} ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic r0_vld = 0, r1_vld = 0, add_rdy = 0, sum_vld = 0, o0_rdy = 1, o1_rdy = 1;
  vec_t r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0, sum_in = '0;
  logic r0_rdy, r1_rdy, add_vld, sum_rdy, o0_vld, o1_vld, err;
  vec_t add_a, add_b, o0_sum, o1_sum;
  logic [2:0] inflight;

  int tests = 0;
  int fails = 0;

  vec_add_arbiter #(.VEC_LEN(4), .DATA_WIDTH(8), .TAG_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .r0_vld(r0_vld), .r0_rdy(r0_rdy), .r0_a(r0_a), .r0_b(r0_b),
    .r1_vld(r1_vld), .r1_rdy(r1_rdy), .r1_a(r1_a), .r1_b(r1_b),
    .add_vld(add_vld), .add_rdy(add_rdy), .add_a(add_a), .add_b(add_b),
    .sum_vld(sum_vld), .sum_rdy(sum_rdy), .sum_in(sum_in),
    .o0_vld(o0_vld), .o0_rdy(o0_rdy), .o0_sum(o0_sum),
    .o1_vld(o1_vld), .o1_rdy(o1_rdy), .o1_sum(o1_sum),
    .inflight(inflight), .err(err)
  );

  always #5 clk = ~clk;

  function automatic vec_t vadd(vec_t a, vec_t b);
    vec_t r;
    for (int i = 0; i < 4; i++) r[i] = a[i] + b[i];
    return r;
  endfunction

  function automatic vec_t vrand();
    vec_t r;
    for (int i = 0; i < 4; i++) r[i] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_vld = 0; r1_vld = 0; add_rdy = 0; sum_vld = 0; o0_rdy = 1; o1_rdy = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    tick();
    rst = 1;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    r0_vld = 1; r1_vld = 1; add_rdy = 1; sum_vld = 1; r0_a = 8'h11; r1_a = 8'h22;
    #2;
    tests++; if (add_vld !== 1'b0) begin fails++; $display("FAIL rst_add_vld got=%0b exp=0", add_vld); end
    tests++; if (r0_rdy !== 1'b0 || r1_rdy !== 1'b0) begin fails++; $display("FAIL rst_rdy got=%0b%0b exp=00", r0_rdy, r1_rdy); end
    tests++; if (sum_rdy !== 1'b0) begin fails++; $display("FAIL rst_sum_rdy got=%0b exp=0", sum_rdy); end
    tests++; if (o0_vld !== 1'b0 || o1_vld !== 1'b0) begin fails++; $display("FAIL rst_o_vld got=%0b%0b exp=00", o0_vld, o1_vld); end
    tests++; if (inflight !== 3'd0) begin fails++; $display("FAIL rst_inflight got=%0d exp=0", inflight); end
    tests++; if (add_a !== '0) begin fails++; $display("FAIL rst_add_a got=%h exp=0", add_a); end
    do_reset();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got=%0b exp=0", err); end
  endtask

  task automatic test_alternate();
    vec_t exp_a;
    do_reset();
    r0_a = vrand(); r1_a = vrand(); r0_b = vrand(); r1_b = vrand();
    r0_vld = 1; r1_vld = 1; add_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_a = (i % 2 == 0) ? r0_a : r1_a;
      tests++; if (add_vld !== 1'b1) begin fails++; $display("FAIL alt_add_vld i=%0d got=%0b exp=1", i, add_vld); end
      tests++; if (r0_rdy !== (i % 2 == 0) || r1_rdy !== (i % 2 == 1)) begin fails++; $display("FAIL alt_grant i=%0d got r0=%0b r1=%0b exp r%0d", i, r0_rdy, r1_rdy, i % 2); end
      tests++; if (add_a !== exp_a) begin fails++; $display("FAIL alt_add_a i=%0d got=%h exp=%h", i, add_a, exp_a); end
      tests++; if (inflight !== 3'(i)) begin fails++; $display("FAIL alt_inflight i=%0d got=%0d exp=%0d", i, inflight, i); end
      tick();
    end
    #1;
    tests++; if (add_vld !== 1'b0) begin fails++; $display("FAIL alt_full_add_vld got=%0b exp=0", add_vld); end
    tests++; if (inflight !== 3'd4) begin fails++; $display("FAIL alt_full_inflight got=%0d exp=4", inflight); end
    r0_vld = 0; r1_vld = 0; sum_vld = 1; sum_in = vrand();
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (o0_vld !== (i % 2 == 0) || o1_vld !== (i % 2 == 1)) begin fails++; $display("FAIL alt_route i=%0d got o0=%0b o1=%0b", i, o0_vld, o1_vld); end
      tests++; if (sum_rdy !== 1'b1) begin fails++; $display("FAIL alt_sum_rdy i=%0d got=%0b exp=1", i, sum_rdy); end
      tick();
    end
    sum_vld = 0; #1;
    tests++; if (inflight !== 3'd0) begin fails++; $display("FAIL alt_drain_inflight got=%0d exp=0", inflight); end
  endtask

  task automatic test_in_order();
    vec_t a0, b0, a1, b1, s0, s1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a0[i] = 8'(i + 1); b0[i] = 8'd10; a1[i] = 8'(5 + i * 7); b1[i] = 8'd20;
      s0[i] = 8'(11 + i);
    end
    s1 = vadd(a1, b1);
    r0_vld = 1; r0_a = a0; r0_b = b0; add_rdy = 1;
    #1;
    tests++; if (add_a !== a0 || add_b !== b0) begin fails++; $display("FAIL ord_issue0 got a=%h b=%h exp a=%h b=%h", add_a, add_b, a0, b0); end
    tick();
    r0_vld = 0; r1_vld = 1; r1_a = a1; r1_b = b1;
    #1;
    tests++; if (r1_rdy !== 1'b1 || add_a !== a1) begin fails++; $display("FAIL ord_issue1 got rdy=%0b a=%h exp rdy=1 a=%h", r1_rdy, add_a, a1); end
    tick();
    r1_vld = 0; add_rdy = 0; sum_vld = 1; sum_in = vadd(a0, b0);
    #1;
    tests++; if (o0_vld !== 1'b1 || o0_sum !== s0) begin fails++; $display("FAIL ord_res0 got vld=%0b sum=%h exp vld=1 sum=%h", o0_vld, o0_sum, s0); end
    tests++; if (o1_vld !== 1'b0 || o1_sum !== '0) begin fails++; $display("FAIL ord_res0_other got vld=%0b sum=%h exp 0", o1_vld, o1_sum); end
    tick();
    sum_in = s1;
    #1;
    tests++; if (o1_vld !== 1'b1 || o1_sum !== s1) begin fails++; $display("FAIL ord_res1 got vld=%0b sum=%h exp vld=1 sum=%h", o1_vld, o1_sum, s1); end
    tests++; if (o0_vld !== 1'b0) begin fails++; $display("FAIL ord_res1_other got=%0b exp=0", o0_vld); end
    tick();
    sum_vld = 0;
  endtask

  task automatic test_lock_stall();
    do_reset();
    r0_a = vrand(); r1_a = vrand(); r0_b = vrand(); r1_b = vrand();
    r1_vld = 1; add_rdy = 0;
    #1;
    tests++; if (add_vld !== 1'b1 || add_a !== r1_a) begin fails++; $display("FAIL lock_c0 got vld=%0b a=%h exp a=%h", add_vld, add_a, r1_a); end
    tick();
    r0_vld = 1;
    #1;
    tests++; if (add_a !== r1_a || r0_rdy !== 1'b0) begin fails++; $display("FAIL lock_c1 got a=%h r0_rdy=%0b exp a=%h r0_rdy=0", add_a, r0_rdy, r1_a); end
    tick();
    add_rdy = 1;
    #1;
    tests++; if (add_a !== r1_a || r1_rdy !== 1'b1 || r0_rdy !== 1'b0) begin fails++; $display("FAIL lock_hs got a=%h r1_rdy=%0b r0_rdy=%0b exp r1 wins", add_a, r1_rdy, r0_rdy); end
    tick();
    #1;
    tests++; if (add_a !== r0_a || r0_rdy !== 1'b1) begin fails++; $display("FAIL lock_after got a=%h r0_rdy=%0b exp a=%h r0_rdy=1", add_a, r0_rdy, r0_a); end
    tick();
    r0_vld = 0; r1_vld = 0; add_rdy = 0; sum_vld = 1;
    #1;
    tests++; if (o1_vld !== 1'b1 || o0_vld !== 1'b0) begin fails++; $display("FAIL lock_ret0 got o0=%0b o1=%0b exp o1", o0_vld, o1_vld); end
    tick();
    #1;
    tests++; if (o0_vld !== 1'b1 || o1_vld !== 1'b0) begin fails++; $display("FAIL lock_ret1 got o0=%0b o1=%0b exp o0", o0_vld, o1_vld); end
    tick();
    sum_vld = 0;
  endtask

  task automatic test_full_pop();
    do_reset();
    r0_vld = 1; add_rdy = 1;
    for (int i = 0; i < 4; i++) tick();
    sum_vld = 1;
    #1;
    tests++; if (add_vld !== 1'b0 || r0_rdy !== 1'b0) begin fails++; $display("FAIL full_nobypass got vld=%0b rdy=%0b exp 0", add_vld, r0_rdy); end
    tests++; if (sum_rdy !== 1'b1 || o0_vld !== 1'b1) begin fails++; $display("FAIL full_pop got sum_rdy=%0b o0_vld=%0b exp 1", sum_rdy, o0_vld); end
    tests++; if (inflight !== 3'd4) begin fails++; $display("FAIL full_inflight4 got=%0d exp=4", inflight); end
    tick();
    sum_vld = 0;
    #1;
    tests++; if (inflight !== 3'd3) begin fails++; $display("FAIL full_inflight3 got=%0d exp=3", inflight); end
    tests++; if (add_vld !== 1'b1 || r0_rdy !== 1'b1) begin fails++; $display("FAIL full_reissue got vld=%0b rdy=%0b exp 1", add_vld, r0_rdy); end
    tick();
    r0_vld = 0;
    #1;
    tests++; if (inflight !== 3'd4) begin fails++; $display("FAIL full_refill got=%0d exp=4", inflight); end
  endtask

  task automatic test_err();
    do_reset();
    sum_vld = 1;
    #1;
    tests++; if (sum_rdy !== 1'b0 || o0_vld !== 1'b0 || o1_vld !== 1'b0) begin fails++; $display("FAIL err_rdy got sum_rdy=%0b o0=%0b o1=%0b exp 0", sum_rdy, o0_vld, o1_vld); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_pre got=%0b exp=0", err); end
    tick();
    sum_vld = 0;
    #1;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_set got=%0b exp=1", err); end
    tick(); tick(); tick();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky got=%0b exp=1", err); end
    rst = 0;
    #1;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clear got=%0b exp=0", err); end
    do_reset();
  endtask

  task automatic test_async_reset();
    do_reset();
    r0_vld = 1; add_rdy = 1;
    for (int i = 0; i < 3; i++) tick();
    r1_vld = 1; sum_vld = 1;
    #1;
    tests++; if (inflight !== 3'd3 || add_vld !== 1'b1 || sum_rdy !== 1'b1) begin fails++; $display("FAIL areset_pre got inflight=%0d add_vld=%0b sum_rdy=%0b exp 3/1/1", inflight, add_vld, sum_rdy); end
    #1 rst = 0;
    #1;
    tests++; if (add_vld !== 1'b0 || r0_rdy !== 1'b0 || r1_rdy !== 1'b0) begin fails++; $display("FAIL areset_req got add_vld=%0b r0=%0b r1=%0b exp 0", add_vld, r0_rdy, r1_rdy); end
    tests++; if (sum_rdy !== 1'b0 || o0_vld !== 1'b0 || o1_vld !== 1'b0) begin fails++; $display("FAIL areset_res got sum_rdy=%0b o0=%0b o1=%0b exp 0", sum_rdy, o0_vld, o1_vld); end
    tests++; if (inflight !== 3'd0) begin fails++; $display("FAIL areset_inflight got=%0d exp=0", inflight); end
    idle_inputs();
    tick();
    rst = 1;
    tick(); tick(); tick();
    sum_vld = 1;
    #1;
    tests++; if (sum_rdy !== 1'b0) begin fails++; $display("FAIL areset_stale_rdy got=%0b exp=0", sum_rdy); end
    tick();
    sum_vld = 0;
    #1;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL areset_stale_err got=%0b exp=1", err); end
    do_reset();
  endtask

  task automatic test_random_traffic();
    ent_t mq[$];
    ent_t ent;
    int   rr_m, commit_m, g, head_m;
    bit   full_m, empty_m, e_add_vld, e_r0_rdy, e_r1_rdy, e_sum_rdy, e_o0_vld, e_o1_vld;
    vec_t e_add_a, e_add_b, e_o0_sum, e_o1_sum;
    do_reset();
    rr_m = 0; commit_m = -1;
    for (int c = 0; c < 500; c++) begin
      r0_vld = 1'($urandom_range(0, 1)); r1_vld = 1'($urandom_range(0, 1));
      add_rdy = ($urandom_range(0, 3) != 0);
      o0_rdy = ($urandom_range(0, 3) != 0); o1_rdy = ($urandom_range(0, 3) != 0);
      r0_a = vrand(); r0_b = vrand(); r1_a = vrand(); r1_b = vrand();
      sum_vld = (mq.size() != 0) && ($urandom_range(0, 2) != 0);
      sum_in = sum_vld ? mq[0].sum : vrand();
      #1;
      full_m = (mq.size() == 4);
      empty_m = (mq.size() == 0);
      if (commit_m >= 0)         g = commit_m;
      else if (r0_vld && r1_vld) g = rr_m;
      else                       g = r1_vld ? 1 : 0;
      e_add_vld = (g == 1 ? r1_vld : r0_vld) && !full_m;
      e_r0_rdy = e_add_vld && add_rdy && (g == 0);
      e_r1_rdy = e_add_vld && add_rdy && (g == 1);
      e_add_a = e_add_vld ? (g == 1 ? r1_a : r0_a) : '0;
      e_add_b = e_add_vld ? (g == 1 ? r1_b : r0_b) : '0;
      head_m = empty_m ? 0 : mq[0].tag;
      e_sum_rdy = !empty_m && (head_m == 1 ? o1_rdy : o0_rdy);
      e_o0_vld = sum_vld && !empty_m && head_m == 0;
      e_o1_vld = sum_vld && !empty_m && head_m == 1;
      e_o0_sum = e_o0_vld ? mq[0].sum : '0;
      e_o1_sum = e_o1_vld ? mq[0].sum : '0;
      tests++; if (add_vld !== e_add_vld) begin fails++; $display("FAIL rnd_add_vld c=%0d got=%0b exp=%0b", c, add_vld, e_add_vld); end
      tests++; if (r0_rdy !== e_r0_rdy || r1_rdy !== e_r1_rdy) begin fails++; $display("FAIL rnd_rdy c=%0d got=%0b%0b exp=%0b%0b", c, r0_rdy, r1_rdy, e_r0_rdy, e_r1_rdy); end
      tests++; if (add_a !== e_add_a || add_b !== e_add_b) begin fails++; $display("FAIL rnd_operands c=%0d got=%h/%h exp=%h/%h", c, add_a, add_b, e_add_a, e_add_b); end
      tests++; if (sum_rdy !== e_sum_rdy) begin fails++; $display("FAIL rnd_sum_rdy c=%0d got=%0b exp=%0b", c, sum_rdy, e_sum_rdy); end
      tests++; if (o0_vld !== e_o0_vld || o1_vld !== e_o1_vld) begin fails++; $display("FAIL rnd_o_vld c=%0d got=%0b%0b exp=%0b%0b", c, o0_vld, o1_vld, e_o0_vld, e_o1_vld); end
      tests++; if (o0_sum !== e_o0_sum || o1_sum !== e_o1_sum) begin fails++; $display("FAIL rnd_o_sum c=%0d got=%h/%h exp=%h/%h", c, o0_sum, o1_sum, e_o0_sum, e_o1_sum); end
      tests++; if (inflight !== 3'(mq.size())) begin fails++; $display("FAIL rnd_inflight c=%0d got=%0d exp=%0d", c, inflight, mq.size()); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL rnd_err c=%0d got=%0b exp=0", c, err); end
      if (sum_vld && e_sum_rdy) ent = mq.pop_front();
      if (e_add_vld && add_rdy) begin
        mq.push_back('{g, vadd(e_add_a, e_add_b)});
        rr_m = 1 - g;
        commit_m = -1;
      end else if (e_add_vld) begin
        commit_m = g;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_in_order();
    test_lock_stall();
    test_full_pop();
    test_err();
    test_async_reset();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
